// File: rtl/operand_shifter_if.sv
// Operand shifter bus: operand load/shift commands in,
// shifted operand registers and accumulator controls out.
interface operand_shifter_if #(
    parameter int WIDTH = 8
);
    localparam int MW = 2 * WIDTH - 1;
    localparam int CW = $clog2(WIDTH) + 1;

    logic             load;
    logic             en;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic [MW-1:0]    shifted_multiplicand;
    logic [WIDTH-1:0] shifted_multiplier;
    logic             mult_lsb;
    logic             zflag;
    logic [CW-1:0]    shift_count;

    modport master (
        output load,
        output en,
        output multiplicand,
        output multiplier,
        input  shifted_multiplicand,
        input  shifted_multiplier,
        input  mult_lsb,
        input  zflag,
        input  shift_count
    );

    modport slave (
        input  load,
        input  en,
        input  multiplicand,
        input  multiplier,
        output shifted_multiplicand,
        output shifted_multiplier,
        output mult_lsb,
        output zflag,
        output shift_count
    );
endinterface

// File: rtl/operand_shifter.sv
// Operand shift unit for the shift-and-add multiplier:
// left-shifting multiplicand, right-shifting multiplier.
module operand_shifter #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    operand_shifter_if.slave  bus
);
    localparam int MW = 2 * WIDTH - 1;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [MW-1:0]    md_q;
    logic [WIDTH-1:0] mr_q;
    logic [CW-1:0]    cnt_q;

    // Operand registers: load beats shift, shift beats hold.
    // The multiplicand is zero-extended so the product bits
    // it walks into are already clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_q  <= '0;
            mr_q  <= '0;
            cnt_q <= '0;
        end else if (bus.load) begin
            md_q  <= {{(WIDTH-1){1'b0}}, bus.multiplicand};
            mr_q  <= bus.multiplier;
            cnt_q <= '0;
        end else if (bus.en) begin
            md_q  <= md_q << 1;
            mr_q  <= mr_q >> 1;
            if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Accumulator controls come straight off the multiplier register.
    assign bus.shifted_multiplicand = md_q;
    assign bus.shifted_multiplier   = mr_q;
    assign bus.shift_count          = cnt_q;
    assign bus.mult_lsb             = mr_q[0];
    assign bus.zflag                = (mr_q == '0);
endmodule

// File: tb/tb_operand_shifter.sv
// Directed bench for operand_shifter: reset, load priority,
// shift sequences, saturation, hold and reload.
module tb_operand_shifter;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    operand_shifter_if #(.WIDTH(8)) bus ();

    operand_shifter #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [14:0] md,
                           input logic [7:0] mr, input logic [3:0] cnt);
        chk({tag, ".md"}, 32'(bus.shifted_multiplicand), 32'(md));
        chk({tag, ".mr"}, 32'(bus.shifted_multiplier), 32'(mr));
        chk({tag, ".cnt"}, 32'(bus.shift_count), 32'(cnt));
        chk({tag, ".lsb"}, 32'(bus.mult_lsb), 32'(mr[0]));
        chk({tag, ".z"}, 32'(bus.zflag), 32'(mr == 8'h00));
    endtask

    logic [7:0]  exp_mr [4];
    logic [14:0] exp_md [4];

    initial begin
        tests = 0;
        fails = 0;
        exp_mr = '{8'h06, 8'h03, 8'h01, 8'h00};
        exp_md = '{15'h016A, 15'h02D4, 15'h05A8, 15'h0B50};

        rst = 1'b1;
        bus.load = 1'b0;
        bus.en = 1'b0;
        bus.multiplicand = 8'h00;
        bus.multiplier = 8'h00;
        #12;
        chk_all("reset", 15'h0000, 8'h00, 4'd0);
        rst = 1'b0;

        // reset dominates load
        bus.multiplicand = 8'h12;
        bus.multiplier = 8'h34;
        bus.load = 1'b1;
        rst = 1'b1;
        step();
        chk_all("rst_over_load", 15'h0000, 8'h00, 4'd0);
        rst = 1'b0;

        // async reset between edges after loading FF/FF
        bus.multiplicand = 8'hFF;
        bus.multiplier = 8'hFF;
        bus.load = 1'b1;
        step();
        chk_all("load_ff", 15'h00FF, 8'hFF, 4'd0);
        bus.load = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 15'h0000, 8'h00, 4'd0);
        #1;
        rst = 1'b0;
        bus.en = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk_all("post_rst_shift", 15'h0000, 8'h00, 4'd3);

        // load wins over en
        bus.multiplicand = 8'hB5;
        bus.multiplier = 8'h0D;
        bus.load = 1'b1;
        bus.en = 1'b1;
        step();
        chk_all("load_b5", 15'h00B5, 8'h0D, 4'd0);
        bus.load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_all($sformatf("shift%0d", i + 1), exp_md[i], exp_mr[i],
                    4'(i + 1));
        end

        // boundary: FF x 80, with a hold in the middle
        bus.multiplicand = 8'hFF;
        bus.multiplier = 8'h80;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk_all("bnd3", 15'h07F8, 8'h10, 4'd3);
        bus.en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all($sformatf("hold%0d", i), 15'h07F8, 8'h10, 4'd3);
        end
        bus.en = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk_all("bnd7", 15'h7F80, 8'h01, 4'd7);
        step();
        chk_all("bnd8", 15'h7F00, 8'h00, 4'd8);
        step();
        chk_all("bnd9", 15'h7E00, 8'h00, 4'd8);
        for (int i = 0; i < 6; i++) step();
        chk_all("bnd15", 15'h0000, 8'h00, 4'd8);

        // reload while shifting
        bus.multiplicand = 8'hB5;
        bus.multiplier = 8'h0D;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        step();
        step();
        chk_all("pre_reload", 15'h02D4, 8'h03, 4'd2);
        bus.multiplicand = 8'h03;
        bus.multiplier = 8'h05;
        bus.load = 1'b1;
        step();
        chk_all("reload", 15'h0003, 8'h05, 4'd0);
        bus.load = 1'b0;
        step();
        chk_all("reload_sh", 15'h0006, 8'h02, 4'd1);

        // mid-operation reset clears until next load
        #2;
        rst = 1'b1;
        #1;
        chk_all("mid_rst", 15'h0000, 8'h00, 4'd0);
        #1;
        rst = 1'b0;
        bus.en = 1'b0;
        step();
        chk_all("mid_rst_hold", 15'h0000, 8'h00, 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
